cp0_multi: RTL and testbench

Parametrised system-control coprocessor for the pipelined MIPS core, sitting beside the MEM/WB stage. Holds Count, Status, Cause and EPC plus NUM_TIMERS independent Compare channels. Sequences exception entry and return (EXL), resolves masked hardware, software and timer interrupts into a single request to the pipeline, and records branch-delay-slot exceptions.

---
 rtl/cp0_multi.sv | 173 +++++++++++++++++
 tb/tb_cp0_multi.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_multi.sv
// System-control coprocessor: Count/Compare timers, Status, Cause, EPC and EXL sequencing.
// Optional macro CP0_WR_BYPASS_EN forwards an mtc0 write straight to rdata in the same cycle.
module cp0_multi #(
   parameter int NUM_HW_INT = 6,
   parameter int NUM_TIMERS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [4:0]            waddr,
   input  logic [31:0]           wdata,
   input  logic [4:0]            raddr,
   output logic [31:0]           rdata,
   input  logic [NUM_HW_INT-1:0] hw_int,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_code,
   input  logic [31:0]           exc_pc,
   input  logic                  exc_bd,
   input  logic                  eret,
   output logic                  int_req,
   output logic [NUM_TIMERS-1:0] timer_irq,
   output logic [31:0]           epc_out,
   output logic [31:0]           status_out,
   output logic [31:0]           cause_out
);

   localparam logic [4:0] ADDR_COUNT  = 5'd9;
   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;

   typedef enum logic {NORMAL, EXC} stateT;

   function automatic logic [4:0] cmpAddr(input int k);
      return (k == 0) ? 5'd11 : 5'(15 + k);
   endfunction

   stateT       stateQ, stateD;
   logic [31:0] countQ, countD;
   logic [31:2] statusHiQ, statusHiD;
   logic        ieQ, ieD;
   logic [1:0]  ipSwQ, ipSwD;
   logic        bdQ, bdD;
   logic [4:0]  excCodeQ, excCodeD;
   logic [31:0] epcQ, epcD;
   logic [31:0] compareQ [NUM_TIMERS];
   logic [31:0] compareD [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] timerIrqQ, timerIrqD;

   logic [5:0]  ipHw;
   logic [31:0] excEpc;
   logic [31:0] rdataReg;

   // IP2..IP7 are live views of the interrupt lines; IP7 also carries any timer match.
   always_comb begin
      ipHw                   = '0;
      ipHw[NUM_HW_INT-1:0]   = hw_int;
      ipHw[5]                = ipHw[5] | (|timerIrqQ);
   end

   assign excEpc     = (exc_code == 5'd8) ? exc_pc + 32'd4 :
                       exc_bd             ? exc_pc - 32'd4 : exc_pc;
   assign status_out = {statusHiQ, stateQ == EXC, ieQ};
   assign cause_out  = {bdQ, 15'b0, ipHw, ipSwQ, 1'b0, excCodeQ, 2'b0};
   assign epc_out    = epcQ;
   assign timer_irq  = timerIrqQ;
   assign int_req    = ieQ & (stateQ == NORMAL) & (|({ipHw, ipSwQ} & statusHiQ[15:8]));

   // Next-state logic: an exception owns EXL/EPC/BD/ExcCode, an mtc0 to Status beats eret.
   always_comb begin
      countD    = (we && waddr == ADDR_COUNT) ? wdata : countQ + 32'd1;
      statusHiD = statusHiQ;
      ieD       = ieQ;
      ipSwD     = ipSwQ;
      bdD       = bdQ;
      excCodeD  = excCodeQ;
      epcD      = epcQ;
      stateD    = stateQ;
      if (we && waddr == ADDR_STATUS) begin
         statusHiD = wdata[31:2];
         ieD       = wdata[0];
      end
      if (we && waddr == ADDR_CAUSE)
         ipSwD = wdata[9:8];
      if (exc_valid) begin
         stateD   = EXC;
         excCodeD = exc_code;
         if (stateQ == NORMAL) begin
            epcD = excEpc;
            bdD  = exc_bd;
         end
      end else begin
         if (we && waddr == ADDR_EPC)
            epcD = wdata;
         if (we && waddr == ADDR_STATUS)
            stateD = wdata[1] ? EXC : NORMAL;
         else if (eret)
            stateD = NORMAL;
      end
      for (int k = 0; k < NUM_TIMERS; k++) begin
         compareD[k]  = compareQ[k];
         timerIrqD[k] = timerIrqQ[k] | ((countQ == compareQ[k]) && (compareQ[k] != 32'd0));
         if (we && waddr == cmpAddr(k)) begin
            compareD[k]  = wdata;
            timerIrqD[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= NORMAL;
         countQ    <= '0;
         statusHiQ <= 30'h0400_0000;
         ieQ       <= 1'b0;
         ipSwQ     <= '0;
         bdQ       <= 1'b0;
         excCodeQ  <= '0;
         epcQ      <= '0;
         timerIrqQ <= '0;
         for (int k = 0; k < NUM_TIMERS; k++) compareQ[k] <= '0;
      end else begin
         stateQ    <= stateD;
         countQ    <= countD;
         statusHiQ <= statusHiD;
         ieQ       <= ieD;
         ipSwQ     <= ipSwD;
         bdQ       <= bdD;
         excCodeQ  <= excCodeD;
         epcQ      <= epcD;
         timerIrqQ <= timerIrqD;
         for (int k = 0; k < NUM_TIMERS; k++) compareQ[k] <= compareD[k];
      end
   end

   // mfc0 read mux; absent Compare channels and unmapped numbers read as zero.
   always_comb begin
      rdataReg = '0;
      case (raddr)
         ADDR_COUNT:  rdataReg = countQ;
         ADDR_STATUS: rdataReg = status_out;
         ADDR_CAUSE:  rdataReg = cause_out;
         ADDR_EPC:    rdataReg = epcQ;
         default: begin
            for (int k = 0; k < NUM_TIMERS; k++)
               if (raddr == cmpAddr(k)) rdataReg = compareQ[k];
         end
      endcase
   end

`ifdef CP0_WR_BYPASS_EN
   logic rMapped;

   always_comb begin
      rMapped = (raddr == ADDR_COUNT) || (raddr == ADDR_STATUS) ||
                (raddr == ADDR_CAUSE) || (raddr == ADDR_EPC);
      for (int k = 0; k < NUM_TIMERS; k++)
         if (raddr == cmpAddr(k)) rMapped = 1'b1;
   end

   always_comb begin
      if (rst)
         rdata = '0;
      else if (we && waddr == raddr && rMapped)
         rdata = (raddr == ADDR_CAUSE) ? {16'b0, ipHw, wdata[9:8], 8'b0} : wdata;
      else
         rdata = rdataReg;
   end
`else
   assign rdata = rst ? 32'd0 : rdataReg;
`endif

endmodule

// File: tb/tb_cp0_multi.sv
// Directed testbench for cp0_multi with hand-computed expectations (default parameters).
module tb_cp0_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic [5:0]  hw_int;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        eret;
   logic        int_req;
   logic [1:0]  timer_irq;
   logic [31:0] epc_out;
   logic [31:0] status_out;
   logic [31:0] cause_out;

   int vecCount  = 0;
   int missCount = 0;

   always #5 clk = ~clk;

   cp0_multi #(.NUM_HW_INT(6), .NUM_TIMERS(2)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
      .rdata(rdata), .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code),
      .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret), .int_req(int_req),
      .timer_irq(timer_irq), .epc_out(epc_out), .status_out(status_out),
      .cause_out(cause_out)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
      we    = 1'b1;
      waddr = addr;
      wdata = data;
      tick();
      we    = 1'b0;
   endtask

   task automatic raiseException(input logic [4:0] code, input logic [31:0] pc, input logic bd);
      exc_valid = 1'b1;
      exc_code  = code;
      exc_pc    = pc;
      exc_bd    = bd;
      tick();
      exc_valid = 1'b0;
   endtask

   task automatic doEret;
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [4:0] addr, input logic [31:0] expected);
      raddr = addr;
      #1;
      checkOutput(tag, rdata, expected);
   endtask

   initial begin
      int waitCycles;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = 5'd12;
      hw_int = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; eret = 1'b0;
      tick(); tick(); tick();

      checkOutput("rdata_in_reset", rdata, 32'd0);
      checkOutput("status_reset", status_out, 32'h1000_0000);
      checkOutput("cause_reset", cause_out, 32'd0);
      checkOutput("epc_reset", epc_out, 32'd0);
      checkOutput("int_req_reset", 32'(int_req), 32'd0);
      checkOutput("timer_irq_reset", 32'(timer_irq), 32'd0);

      rst = 1'b0;
      readCheck("count_0", 5'd9, 32'd0);
      tick();
      readCheck("count_1", 5'd9, 32'd1);
      tick();
      readCheck("count_2", 5'd9, 32'd2);
      readCheck("compare0_reset", 5'd11, 32'd0);
      tick();
      readCheck("status_read", 5'd12, 32'h1000_0000);
      readCheck("cause_read", 5'd13, 32'd0);
      readCheck("epc_read", 5'd14, 32'd0);

      // Timer channel 1
      applyStimulus(5'd16, 32'd20);
      applyStimulus(5'd12, 32'h0000_8001);
      applyStimulus(5'd9, 32'd10);
      readCheck("compare1_read", 5'd16, 32'd20);
      waitCycles = 0;
      while (timer_irq[1] !== 1'b1 && waitCycles < 30) begin
         tick();
         waitCycles++;
      end
      checkOutput("timer_latency", 32'(waitCycles), 32'd11);
      checkOutput("timer_irq_set", 32'(timer_irq), 32'b10);
      checkOutput("cause_ip7", cause_out, 32'h0000_8000);
      checkOutput("int_req_timer", 32'(int_req), 32'd1);
      applyStimulus(5'd16, 32'd0);
      checkOutput("timer_irq_clear", 32'(timer_irq), 32'd0);
      checkOutput("int_req_timer_off", 32'(int_req), 32'd0);

      // Hardware interrupt masking
      hw_int = 6'b000001;
      #1;
      checkOutput("cause_ip2", cause_out, 32'h0000_0400);
      checkOutput("int_req_masked", 32'(int_req), 32'd0);
      applyStimulus(5'd12, 32'h0000_0401);
      checkOutput("int_req_im2", 32'(int_req), 32'd1);

      // Syscall entry and return
      raiseException(5'd8, 32'h100, 1'b0);
      checkOutput("epc_sys", epc_out, 32'h104);
      checkOutput("cause_sys", cause_out, 32'h0000_0420);
      checkOutput("status_exl", status_out, 32'h0000_0403);
      checkOutput("int_req_exl", 32'(int_req), 32'd0);
      doEret();
      checkOutput("status_eret", status_out, 32'h0000_0401);
      checkOutput("int_req_after_eret", 32'(int_req), 32'd1);
      hw_int = '0;
      #1;
      checkOutput("int_req_hw_low", 32'(int_req), 32'd0);

      // Delay-slot exception, then nested exception
      raiseException(5'd0, 32'h200, 1'b1);
      checkOutput("epc_bd", epc_out, 32'h1FC);
      checkOutput("cause_bd", cause_out, 32'h8000_0000);
      raiseException(5'd8, 32'h300, 1'b0);
      checkOutput("epc_nested", epc_out, 32'h1FC);
      checkOutput("cause_nested", cause_out, 32'h8000_0020);
      doEret();
      checkOutput("status_eret2", status_out, 32'h0000_0401);

      // Software interrupts
      applyStimulus(5'd12, 32'h0000_0101);
      applyStimulus(5'd13, 32'h0000_0300);
      checkOutput("cause_sw", cause_out, 32'h8000_0320);
      checkOutput("int_req_sw", 32'(int_req), 32'd1);
      applyStimulus(5'd13, 32'h0000_0000);
      checkOutput("cause_sw_clr", cause_out, 32'h8000_0020);
      checkOutput("int_req_sw_clr", 32'(int_req), 32'd0);

      // Same-cycle priority: exception over eret and over mtc0 EPC
      we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF; eret = 1'b1;
      raiseException(5'd4, 32'h400, 1'b0);
      we = 1'b0; eret = 1'b0;
      checkOutput("prio_status", status_out, 32'h0000_0103);
      checkOutput("prio_epc", epc_out, 32'h400);
      checkOutput("prio_cause", cause_out, 32'h0000_0010);
      eret = 1'b1;
      applyStimulus(5'd12, 32'h0000_0103);
      eret = 1'b0;
      checkOutput("mtc0_beats_eret", status_out, 32'h0000_0103);
      doEret();
      checkOutput("eret_normal_exit", status_out, 32'h0000_0101);
      doEret();
      checkOutput("eret_in_normal", status_out, 32'h0000_0101);
      applyStimulus(5'd14, 32'h0000_1234);
      checkOutput("epc_write", epc_out, 32'h0000_1234);

      // Absent channel and unmapped register
      applyStimulus(5'd18, 32'd5);
      readCheck("absent_cmp", 5'd18, 32'd0);
      readCheck("unmapped", 5'd3, 32'd0);

      // Same-cycle read of a register being written
      raddr = 5'd12; we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0F01;
      #1;
`ifdef CP0_WR_BYPASS_EN
      checkOutput("bypass_status", rdata, 32'h0000_0F01);
`else
      checkOutput("no_bypass_status", rdata, 32'h0000_0101);
`endif
      tick();
      we = 1'b0;
      checkOutput("status_written", rdata, 32'h0000_0F01);

      // Count wrap
      applyStimulus(5'd9, 32'hFFFF_FFFF);
      readCheck("count_max", 5'd9, 32'hFFFF_FFFF);
      tick();
      checkOutput("count_wrap", rdata, 32'd0);

      // Reset while in EXC
      raiseException(5'd0, 32'h500, 1'b0);
      checkOutput("exc_before_rst", status_out, 32'h0000_0F03);
      rst = 1'b1;
      #1;
      checkOutput("rdata_rst_high", rdata, 32'd0);
      tick();
      rst = 1'b0;
      checkOutput("status_after_rst", status_out, 32'h1000_0000);
      checkOutput("epc_after_rst", epc_out, 32'd0);
      checkOutput("cause_after_rst", cause_out, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
